// File: rtl/mem_access_unit_if.sv
// Memory bus between mem_access_unit and an external word-addressed memory.
//   master : the access unit (drives MemReq/MemWe/MemAddr/MemWData)
//   slave  : the memory (drives MemRData/MemAck)
// MemAck is a single-cycle completion strobe; MemRData is valid with it.
interface mem_access_unit_if #(
   parameter int ADDR_WIDTH = 30
);
   logic                  MemReq;
   logic                  MemWe;
   logic [ADDR_WIDTH-1:0] MemAddr;
   logic [31:0]           MemWData;
   logic [31:0]           MemRData;
   logic                  MemAck;

   modport master (
      output MemReq, MemWe, MemAddr, MemWData,
      input  MemRData, MemAck
   );

   modport slave (
      input  MemReq, MemWe, MemAddr, MemWData,
      output MemRData, MemAck
   );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-side stage downstream of the multicycle controller. Converts the
// controller's MemRead/MemWrite/IorD/IRWrite strobes into one req/ack
// transaction on a variable-latency memory, loads IR/MDR from read data,
// and reports completion (MemReady), misalignment (AlignErr) and timeout
// (sticky BusErr).
// Ports:
//   Clk, Reset             clock, synchronous active-high reset
//   MemRead, MemWrite      controller strobes, held until MemReady
//   IorD                   address select: 0 = PC, 1 = ALUOut
//   IRWrite                read result also loads IR
//   PC, ALUOut, WData      byte addresses and store data
//   mem                    memory bus (master side)
//   IR, MDR, Op            instruction/data registers, Op = IR[31:26]
//   MemReady               one-cycle completion pulse
//   AlignErr               one-cycle pulse with MemReady on misaligned access
//   BusErr                 sticky timeout flag, cleared only by Reset
module mem_access_unit #(
   parameter int ADDR_WIDTH = 30,
   parameter int TIMEOUT    = 16
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                MemRead,
   input  logic                MemWrite,
   input  logic                IorD,
   input  logic                IRWrite,
   input  logic [31:0]         PC,
   input  logic [31:0]         ALUOut,
   input  logic [31:0]         WData,
   mem_access_unit_if.master   mem,
   output logic [31:0]         IR,
   output logic [31:0]         MDR,
   output logic [5:0]          Op,
   output logic                MemReady,
   output logic                AlignErr,
   output logic                BusErr
);

   localparam int             CW   = $clog2(TIMEOUT);
   localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                state;
   state_t                state_next;
   logic [31:0]           eff_addr;
   logic                  misaligned;
   logic                  start;
   logic                  timed_out;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
   logic                  we_q;
   logic                  ir_flag;
   logic [CW-1:0]         cnt;

   always_comb begin
      eff_addr   = IorD ? ALUOut : PC;
      misaligned = (eff_addr[1:0] != 2'b00);
      start      = MemRead | MemWrite;
      timed_out  = (cnt == LAST);
   end

   // State register
   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic; an ack in the final counted cycle still completes
   // normally because the ack test is independent of the timeout test.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (start) state_next = misaligned ? DONE : BUSY;
         BUSY: if (mem.MemAck || timed_out) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs decoded from state; MemWe is only meaningful while requesting.
   always_comb begin
      mem.MemReq   = (state == BUSY);
      mem.MemWe    = we_q && (state == BUSY);
      mem.MemAddr  = addr_q;
      mem.MemWData = wdata_q;
      MemReady     = (state == DONE);
      Op           = IR[31:26];
   end

   // Request latch, timeout counter, IR/MDR and error flags
   always_ff @(posedge Clk) begin
      if (Reset) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         ir_flag  <= 1'b0;
         cnt      <= '0;
         IR       <= '0;
         MDR      <= '0;
         AlignErr <= 1'b0;
         BusErr   <= 1'b0;
      end else begin
         AlignErr <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (misaligned) begin
                     AlignErr <= 1'b1;
                  end else begin
                     addr_q  <= eff_addr[ADDR_WIDTH+1:2];
                     wdata_q <= WData;
                     we_q    <= MemWrite;
                     // a write wins over a simultaneous read, so never loads IR
                     ir_flag <= IRWrite & ~MemWrite;
                     cnt     <= '0;
                  end
               end
            end
            BUSY: begin
               cnt <= cnt + CW'(1);
               if (mem.MemAck) begin
                  if (!we_q) begin
                     MDR <= mem.MemRData;
                     if (ir_flag) IR <= mem.MemRData;
                  end
               end else if (timed_out) begin
                  BusErr <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit. A transaction-level
// model predicts, from the effective address and the chosen ack cycle,
// how many request cycles occur, when MemReady fires, and the resulting
// IR/MDR/BusErr values.
module tb_mem_access_unit;

   localparam int AW = 30;
   localparam int TO = 16;

   logic        Clk = 1'b0;
   logic        Reset, MemRead, MemWrite, IorD, IRWrite;
   logic [31:0] PC, ALUOut, WData, IR, MDR;
   logic [5:0]  Op;
   logic        MemReady, AlignErr, BusErr;

   mem_access_unit_if #(.ADDR_WIDTH(AW)) mem ();

   mem_access_unit #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .IorD     (IorD),
      .IRWrite  (IRWrite),
      .PC       (PC),
      .ALUOut   (ALUOut),
      .WData    (WData),
      .mem      (mem),
      .IR       (IR),
      .MDR      (MDR),
      .Op       (Op),
      .MemReady (MemReady),
      .AlignErr (AlignErr),
      .BusErr   (BusErr)
   );

   always #5 Clk = ~Clk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // reference state
   logic [31:0] m_ir  = '0;
   logic [31:0] m_mdr = '0;
   logic        m_buserr = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input int cycles);
      @(negedge Clk);
      Reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; MemAck_drive(1'b0);
      repeat (cycles) @(negedge Clk);
      Reset = 1'b0;
      m_ir = '0; m_mdr = '0; m_buserr = 1'b0;
   endtask

   task automatic MemAck_drive(input logic v);
      mem.MemAck = v;
   endtask

   // One controller transaction. ack_k = BUSY cycle on which memory acks
   // (0 = never). Returns after the cycle following MemReady.
   task automatic access(input string tag, input logic rd, input logic wr,
                         input logic iord, input logic irw,
                         input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] wd, input int ack_k,
                         input logic [31:0] rdata);
      logic [31:0]   eff;
      logic [AW-1:0] exp_addr;
      bit            aligned, bus_ok, align_at_ready;
      int            req_cycles, ready_at, align_cycles, exp_req, exp_ready;

      eff      = iord ? alu : pc;
      aligned  = (eff[1:0] == 2'b00);
      exp_addr = eff[31:2];

      @(negedge Clk);
      MemRead = rd; MemWrite = wr; IorD = iord; IRWrite = irw;
      PC = pc; ALUOut = alu; WData = wd; mem.MemAck = 1'b0;
      req_cycles = 0; ready_at = -1; align_cycles = 0;
      bus_ok = 1'b1; align_at_ready = 1'b0;

      for (int c = 0; c < TO + 6; c++) begin
         if (c > 0) @(negedge Clk);
         if (AlignErr) align_cycles++;
         if (mem.MemReq) begin
            req_cycles++;
            if (mem.MemAddr !== exp_addr || mem.MemWe !== wr || mem.MemWData !== wd)
               bus_ok = 1'b0;
         end
         if (mem.MemReq && req_cycles == ack_k) begin
            mem.MemAck = 1'b1; mem.MemRData = rdata;
         end else begin
            // spurious acks outside a request must be ignored
            mem.MemAck = !mem.MemReq && ($urandom_range(0, 1) == 1);
            mem.MemRData = $urandom;
         end
         if (MemReady) begin
            ready_at = c; align_at_ready = AlignErr;
            MemRead = 1'b0; MemWrite = 1'b0;
            break;
         end
      end

      @(negedge Clk);
      mem.MemAck = 1'b0;
      check({tag, ".ready_pulse"}, MemReady, 0);

      if (!aligned) begin
         exp_req = 0; exp_ready = 1;
      end else if (ack_k >= 1 && ack_k <= TO) begin
         exp_req = ack_k; exp_ready = ack_k + 1;
         if (!wr) begin
            m_mdr = rdata;
            if (irw) m_ir = rdata;
         end
      end else begin
         exp_req = TO; exp_ready = TO + 1;
         m_buserr = 1'b1;
      end

      check({tag, ".req_cycles"}, req_cycles, exp_req);
      check({tag, ".ready_at"}, ready_at, exp_ready);
      check({tag, ".align_cycles"}, align_cycles, aligned ? 0 : 1);
      check({tag, ".align_at_ready"}, align_at_ready, !aligned);
      if (exp_req > 0) check({tag, ".bus_fields"}, bus_ok, 1);
      check({tag, ".IR"}, IR, m_ir);
      check({tag, ".MDR"}, MDR, m_mdr);
      check({tag, ".Op"}, Op, m_ir[31:26]);
      check({tag, ".BusErr"}, BusErr, m_buserr);
   endtask

   initial begin : stim
      int busy_seen;
      logic [31:0] a;
      int sel;

      Reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; IorD = 1'b0; IRWrite = 1'b0;
      PC = '0; ALUOut = '0; WData = '0; mem.MemAck = 1'b0; mem.MemRData = '0;

      do_reset(2);
      check("rst.MemReq", mem.MemReq, 0);
      check("rst.MemWe", mem.MemWe, 0);
      check("rst.MemReady", MemReady, 0);
      check("rst.AlignErr", AlignErr, 0);
      check("rst.BusErr", BusErr, 0);
      check("rst.MemAddr", mem.MemAddr, 0);
      check("rst.MemWData", mem.MemWData, 0);
      check("rst.IR", IR, 0);
      check("rst.MDR", MDR, 0);
      check("rst.Op", Op, 0);

      access("fetch", 1, 0, 0, 1, 32'h0000_0040, 32'h0, 32'h0, 2, 32'h0123_4820);
      access("load", 1, 0, 1, 0, 32'h0, 32'h0000_1004, 32'h0, 3, 32'hDEAD_BEEF);
      access("store", 1, 1, 1, 1, 32'h0, 32'h0000_2000, 32'hA5A5_5A5A, 1, 32'h1111_2222);
      access("misalign", 1, 0, 1, 1, 32'h0, 32'h0000_1002, 32'h0, 1, 32'h3333_4444);
      access("opfetch", 1, 0, 0, 1, 32'h0000_0100, 32'h0, 32'h0, 1, 32'h8C22_0004);
      access("timeout", 1, 0, 1, 0, 32'h0, 32'h0000_3000, 32'h0, 0, 32'h0);
      access("after_to", 1, 0, 1, 0, 32'h0, 32'h0000_3004, 32'h0, 4, 32'h5555_6666);

      // reset on the third BUSY cycle, then a late ack that must be ignored
      @(negedge Clk);
      MemRead = 1'b1; IorD = 1'b0; IRWrite = 1'b1; PC = 32'h0000_0080; mem.MemAck = 1'b0;
      busy_seen = 0;
      for (int c = 0; c < 10 && busy_seen < 3; c++) begin
         @(negedge Clk);
         if (mem.MemReq) busy_seen++;
      end
      check("midrst.busy_seen", busy_seen, 3);
      Reset = 1'b1; MemRead = 1'b0; IRWrite = 1'b0;
      @(negedge Clk);
      Reset = 1'b0; mem.MemAck = 1'b1; mem.MemRData = 32'hFEED_F00D;
      m_ir = '0; m_mdr = '0; m_buserr = 1'b0;
      check("midrst.MemReq", mem.MemReq, 0);
      check("midrst.MemReady", MemReady, 0);
      check("midrst.MemAddr", mem.MemAddr, 0);
      check("midrst.IR", IR, 0);
      check("midrst.MDR", MDR, 0);
      check("midrst.BusErr", BusErr, 0);
      @(negedge Clk);
      mem.MemAck = 1'b0;
      check("midrst.ready_late", MemReady, 0);
      check("midrst.req_late", mem.MemReq, 0);
      check("midrst.MDR_late", MDR, 0);

      access("refetch", 1, 0, 0, 1, 32'h0000_0080, 32'h0, 32'h0, 1, 32'h2008_0005);
      access("ack_last", 1, 0, 1, 0, 32'h0, 32'h0000_4000, 32'h0, TO, 32'h7777_8888);

      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 2);
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         access("rand", (sel != 1), (sel != 0), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, a, a ^ 32'h0000_0F00, $urandom,
                $urandom_range(0, TO + 2), $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
